mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Pipelined load/store unit for the MIPS core's memory stage, replacing the single-cycle data-SRAM path with an SRAM-like split-transaction bus (`req`/`addr_ok`/`data_ok`). It keeps up to `DEPTH` accesses in flight and checks alignment at issue. Load results are formatted (byte/half extraction, sign/zero extension) and retired strictly in program order, with a per-access tag and exception information handed to WB. Pipeline flush is supported while bus responses are still outstanding.

## Interface
- `DEPTH`, 2, maximum in-flight accesses, power of two ≥2
- `TAG_W`, 38, opaque sideband carried from EX to WB (rf_we, rf_waddr, pc, …)
- `clk` in 1 clock, rising edge
- `rst_n` in 1 reset, asynchronous, active-low
- `flush` in 1 exception/ERET flush from CP0 logic
- `in_valid` in 1 EX offers an access
- `in_ready` out 1 access accepted when `in_valid && in_ready`
- `in_op` in 4 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW, 8 LWL, 9 LWR, 10 SWL, 11 SWR, others reserved
- `in_addr` in 32 effective address
- `in_wdata` in 32 store data, or old rt value for LWL/LWR
- `in_tag` in TAG_W sideband
- `bus_req` out 1 request valid
- `bus_wr` out 1 1 = store
- `bus_size` out 2 0 byte, 1 half, 2 word
- `bus_wstrb` out 4 byte strobes, zero for loads
- `bus_addr` out 32 request address, word-aligned for LWL/LWR/SWL/SWR
- `bus_wdata` out 32 store data replicated/shifted into lanes
- `bus_addr_ok` in 1 request accepted this cycle
- `bus_data_ok` in 1 response (load data or store ack) for oldest outstanding request
- `bus_rdata` in 32 load data
- `out_valid` out 1 retiring access
- `out_ready` in 1 WB accepts
- `out_data` out 32 formatted load result, 0 for stores
- `out_tag` out TAG_W sideband of retiring access
- `out_exc` out 1 retiring access faulted
- `out_exc_code` out 5 5'h04 AdEL, 5'h05 AdES, 5'h0a RI
- `out_badvaddr` out 32 faulting address, 0 when `out_exc`=0

## Operation
- Circular FIFO of `DEPTH` entries {op, addr[1:0], badvaddr, wdata, tag, exc, code, done, kill, rdata}; wr/rd pointers `log2(DEPTH)+1` bits, wrap naturally; full = MSBs differ and LSBs equal.
- Fault check at issue: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]≠0 → AdEL (loads) / AdES (stores); reserved op → RI.
- Faulting access: `bus_req`=0; enqueued with exc=1, done=1; `in_ready` = !full.
- Non-faulting access: `bus_req` = `in_valid && !full && !flush`; `in_ready` = !full && `bus_addr_ok`; entry enqueued on acceptance with done=0.
- Store strobes: SB `4'b0001<<addr[1:0]`, SH `4'b0011<<addr[1:0]`, SW `4'hf`.
- `bus_data_ok` sets done and captures `bus_rdata` into the oldest not-done entry. A separate response pointer tracks it; it is not the head entry.
- Load formatting uses the lane selected by addr[1:0], little-endian. LB/LH sign-extend; LBU/LHU zero-extend.
- Retire: `out_valid` = head.done && !head.kill. Pop on `out_valid && out_ready`. Head with kill=1 and done=1 pops silently without asserting `out_valid`.
- Flush: every entry with done=1 is dropped. Every entry with done=0 gets kill=1; its later `data_ok` is absorbed. `in_ready` and `bus_req` are 0 during the flush cycle. A flush coinciding with `data_ok` treats that entry as done, so it is dropped.
- Accesses accepted after a flush wait behind killed entries; order is never violated.
- `out_exc` does not self-flush; CP0 logic asserts `flush`.

## Timing
- Reset (async, `rst_n`=0): pointers, all valid/done/kill bits and the response pointer cleared; `out_valid`=0, `out_data`=0, `out_exc`=0, `out_badvaddr`=0. `bus_req`=0 and `in_ready`=1 follow combinationally.
- Reset mid-transaction discards all state; the bus is reset together with the core.
- Minimum load latency: accept in cycle N, `data_ok` in N+1, `out_valid` in N+2.
- Fault: accept in N, `out_valid` in N+1 if the entry is at the head.
- No enqueue bypass when full: a full FIFO blocks `in_ready` even if a pop happens the same cycle.
- Enqueue and pop in the same cycle are allowed when not full.
- `bus_data_ok` while no entry is outstanding is a bus protocol error and is ignored.

## Configuration
- `MEM_LR_EN` defined: LWL/LWR/SWL/SWR supported.
  - Word-aligned bus address; never fault.
  - LWL/LWR merge `bus_rdata` with stored old rt per addr[1:0], MIPS little-endian rules.
  - SWL/SWR strobes: SWL `4'b0001,0011,0111,1111`; SWR `4'b1111,1110,1100,1000` for addr[1:0]=0..3.
- Undefined: ops 8–11 are reserved and raise RI.

## Test plan
- LB at 0x1003, rdata 0x80aa_bbcc, `data_ok` next cycle → `out_data` 0xffff_ff80, strobes 0, `out_valid` in cycle N+2.
- SW at 0x2002 → no `bus_req`; `out_exc`=1, code 5'h05, `out_badvaddr` 0x0000_2002 in N+1.
- DEPTH=2, `addr_ok` always 1, `data_ok` withheld → third access sees `in_ready`=0. Two `data_ok` return 0x11, 0x22 → retired in order, tags preserved.
- Two loads outstanding, then `flush` → both later `data_ok` absorbed with no `out_valid`. A load issued after the flush retires with its own data.
- `out_ready`=0 for 5 cycles with the head done → `out_valid` and `out_data` held stable; data captured for the second entry is not lost.
- `MEM_LR_EN`: LWL at 0x0001, old rt 0x1122_3344, rdata 0xaabb_ccdd → 0xccdd_3344. Without the macro: code 5'h0a.

Source files
------------

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : SRAM-like split-transaction data bus (req/addr_ok/data_ok).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Pipelined in-order load/store unit for the memory stage.
//               Optional macro MEM_LR_EN enables LWL/LWR/SWL/SWR.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 38
) (
    input  wire                 clk,
    input  wire                 rst_n,
    input  wire                 flush,
    input  wire                 in_valid,
    output logic                in_ready,
    input  wire  [3:0]          in_op,
    input  wire  [31:0]         in_addr,
    input  wire  [31:0]         in_wdata,
    input  wire  [TAG_W-1:0]    in_tag,
    mem_access_unit_if.master   bus,
    output logic                out_valid,
    input  wire                 out_ready,
    output logic [31:0]         out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_exc,
    output logic [4:0]          out_exc_code,
    output logic [31:0]         out_badvaddr
);
    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W:0] ptr_t;

    localparam logic [3:0] OP_LB  = 4'd0,  OP_LBU = 4'd1, OP_LH  = 4'd2, OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4,  OP_SB  = 4'd5, OP_SH  = 4'd6, OP_SW  = 4'd7;
    localparam logic [3:0] OP_LWL = 4'd8,  OP_LWR = 4'd9, OP_SWL = 4'd10, OP_SWR = 4'd11;

    ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rsp_ptr_q, rsp_ptr_d;
    logic [DEPTH-1:0] done_q, done_d, kill_q, kill_d, exc_q, exc_d;
    logic [3:0]       op_q[DEPTH],       op_d[DEPTH];
    logic [1:0]       lane_q[DEPTH],     lane_d[DEPTH];
    logic [4:0]       code_q[DEPTH],     code_d[DEPTH];
    logic [31:0]      badvaddr_q[DEPTH], badvaddr_d[DEPTH];
    logic [31:0]      rdata_q[DEPTH],    rdata_d[DEPTH];
    logic [TAG_W-1:0] tag_q[DEPTH],      tag_d[DEPTH];
`ifdef MEM_LR_EN
    logic [31:0]      wdata_q[DEPTH],    wdata_d[DEPTH];
`endif

    logic        is_store, reserved, misalign, fault, accept, full, empty;
    logic        head_done, pop, rsp_hit, found, rsp_found;
    logic [4:0]  exc_code;
    logic [1:0]  req_size;
    logic [3:0]  req_strb;
    logic [31:0] req_addr, req_wdata;
    logic [PTR_W-1:0] head;
    ptr_t        first_nd, last_nd, idx, rsp_idx;

    // Issue-side decode: alignment/RI check and lane placement of store data
    always_comb begin
        is_store  = 1'b0;
        reserved  = 1'b0;
        misalign  = 1'b0;
        req_size  = 2'd2;
        req_strb  = 4'h0;
        req_addr  = in_addr;
        req_wdata = in_wdata;
        case (in_op)
            OP_LB, OP_LBU: req_size = 2'd0;
            OP_LH, OP_LHU: begin req_size = 2'd1; misalign = in_addr[0]; end
            OP_LW:         misalign = |in_addr[1:0];
            OP_SB: begin
                is_store  = 1'b1;
                req_size  = 2'd0;
                req_strb  = 4'b0001 << in_addr[1:0];
                req_wdata = {4{in_wdata[7:0]}};
            end
            OP_SH: begin
                is_store  = 1'b1;
                req_size  = 2'd1;
                misalign  = in_addr[0];
                req_strb  = 4'b0011 << in_addr[1:0];
                req_wdata = {2{in_wdata[15:0]}};
            end
            OP_SW: begin
                is_store = 1'b1;
                misalign = |in_addr[1:0];
                req_strb = 4'hf;
            end
`ifdef MEM_LR_EN
            OP_LWL, OP_LWR: req_addr = {in_addr[31:2], 2'b00};
            OP_SWL: begin
                is_store  = 1'b1;
                req_addr  = {in_addr[31:2], 2'b00};
                req_strb  = 4'b1111 >> (2'd3 - in_addr[1:0]);
                req_wdata = in_wdata >> {(2'd3 - in_addr[1:0]), 3'b000};
            end
            OP_SWR: begin
                is_store  = 1'b1;
                req_addr  = {in_addr[31:2], 2'b00};
                req_strb  = 4'b1111 << in_addr[1:0];
                req_wdata = in_wdata << {in_addr[1:0], 3'b000};
            end
`endif
            default: reserved = 1'b1;
        endcase
    end

    assign fault    = reserved | misalign;
    assign exc_code = reserved ? 5'h0a : (is_store ? 5'h05 : 5'h04);

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = rd_ptr_q[PTR_W-1:0];

    assign bus.req   = in_valid && !full && !flush && !fault;
    assign bus.wr    = is_store;
    assign bus.size  = req_size;
    assign bus.wstrb = req_strb;
    assign bus.addr  = req_addr;
    assign bus.wdata = req_wdata;

    assign in_ready  = !full && !flush && (fault || bus.addr_ok);
    assign accept    = in_valid && in_ready;
    assign head_done = !empty && done_q[head];
    assign out_valid = head_done && !kill_q[head];
    assign pop       = head_done && (kill_q[head] || out_ready);
    assign rsp_hit   = bus.data_ok && (rsp_ptr_q != wr_ptr_q);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        done_d     = done_q;
        kill_d     = kill_q;
        exc_d      = exc_q;
        op_d       = op_q;
        lane_d     = lane_q;
        code_d     = code_q;
        badvaddr_d = badvaddr_q;
        rdata_d    = rdata_q;
        tag_d      = tag_q;
`ifdef MEM_LR_EN
        wdata_d    = wdata_q;
`endif
        found      = 1'b0;
        first_nd   = wr_ptr_q;
        last_nd    = wr_ptr_q;
        idx        = '0;
        rsp_found  = 1'b0;
        rsp_idx    = '0;

        if (rsp_hit) begin
            done_d[rsp_ptr_q[PTR_W-1:0]]  = 1'b1;
            rdata_d[rsp_ptr_q[PTR_W-1:0]] = bus.rdata;
        end

        if (flush) begin
            // Keep only the span that still owes a bus response; finished
            // entries inside that span are killed and later pop silently.
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + ptr_t'(i);
                if (ptr_t'(i) < ptr_t'(wr_ptr_q - rd_ptr_q) && !done_d[idx[PTR_W-1:0]]) begin
                    if (!found) first_nd = idx;
                    found   = 1'b1;
                    last_nd = idx;
                end
            end
            kill_d   = '1;
            rd_ptr_d = first_nd;
            wr_ptr_d = found ? last_nd + 1'b1 : wr_ptr_q;
        end else begin
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (accept) begin
                op_d[wr_ptr_q[PTR_W-1:0]]       = in_op;
                lane_d[wr_ptr_q[PTR_W-1:0]]     = in_addr[1:0];
                badvaddr_d[wr_ptr_q[PTR_W-1:0]] = fault ? in_addr : 32'h0;
                tag_d[wr_ptr_q[PTR_W-1:0]]      = in_tag;
                exc_d[wr_ptr_q[PTR_W-1:0]]      = fault;
                code_d[wr_ptr_q[PTR_W-1:0]]     = fault ? exc_code : 5'h0;
                done_d[wr_ptr_q[PTR_W-1:0]]     = fault;
                kill_d[wr_ptr_q[PTR_W-1:0]]     = 1'b0;
`ifdef MEM_LR_EN
                wdata_d[wr_ptr_q[PTR_W-1:0]]    = in_wdata;
`endif
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end

        // Response pointer: oldest entry still waiting for data_ok
        rsp_ptr_d = wr_ptr_d;
        for (int i = 0; i < DEPTH; i++) begin
            rsp_idx = rd_ptr_d + ptr_t'(i);
            if (!rsp_found && ptr_t'(i) < ptr_t'(wr_ptr_d - rd_ptr_d) &&
                !done_d[rsp_idx[PTR_W-1:0]]) begin
                rsp_found = 1'b1;
                rsp_ptr_d = rsp_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rsp_ptr_q  <= '0;
            done_q     <= '0;
            kill_q     <= '0;
            exc_q      <= '0;
            op_q       <= '{default: '0};
            lane_q     <= '{default: '0};
            code_q     <= '{default: '0};
            badvaddr_q <= '{default: '0};
            rdata_q    <= '{default: '0};
            tag_q      <= '{default: '0};
`ifdef MEM_LR_EN
            wdata_q    <= '{default: '0};
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rsp_ptr_q  <= rsp_ptr_d;
            done_q     <= done_d;
            kill_q     <= kill_d;
            exc_q      <= exc_d;
            op_q       <= op_d;
            lane_q     <= lane_d;
            code_q     <= code_d;
            badvaddr_q <= badvaddr_d;
            rdata_q    <= rdata_d;
            tag_q      <= tag_d;
`ifdef MEM_LR_EN
            wdata_q    <= wdata_d;
`endif
        end
    end

    logic [31:0] hr, load_data;
    logic [15:0] lane_data;
    logic [1:0]  hl;

    // Retire-side formatting: little-endian lane extraction and extension
    always_comb begin
        hr        = rdata_q[head];
        hl        = lane_q[head];
        lane_data = 16'(hr >> {hl, 3'b000});
        load_data = 32'h0;
        case (op_q[head])
            OP_LB:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
            OP_LBU: load_data = {24'h0, lane_data[7:0]};
            OP_LH:  load_data = {{16{lane_data[15]}}, lane_data};
            OP_LHU: load_data = {16'h0, lane_data};
            OP_LW:  load_data = hr;
`ifdef MEM_LR_EN
            OP_LWL: case (hl)
                2'd0:    load_data = {hr[7:0],  wdata_q[head][23:0]};
                2'd1:    load_data = {hr[15:0], wdata_q[head][15:0]};
                2'd2:    load_data = {hr[23:0], wdata_q[head][7:0]};
                default: load_data = hr;
            endcase
            OP_LWR: case (hl)
                2'd0:    load_data = hr;
                2'd1:    load_data = {wdata_q[head][31:24], hr[31:8]};
                2'd2:    load_data = {wdata_q[head][31:16], hr[31:16]};
                default: load_data = {wdata_q[head][31:8],  hr[31:24]};
            endcase
`endif
            default: load_data = 32'h0;
        endcase
        out_exc      = out_valid && exc_q[head];
        out_data     = (out_valid && !exc_q[head]) ? load_data : 32'h0;
        out_exc_code = out_exc ? code_q[head] : 5'h0;
        out_badvaddr = out_exc ? badvaddr_q[head] : 32'h0;
        out_tag      = tag_q[head];
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit (DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_wdata = 32'h0;
    logic [37:0] in_tag = 38'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [37:0] out_tag;
    logic        out_exc;
    logic [4:0]  out_exc_code;
    logic [31:0] out_badvaddr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.DEPTH(2), .TAG_W(38)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_tag       (in_tag),
        .bus          (bus_if.master),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_exc      (out_exc),
        .out_exc_code (out_exc_code),
        .out_badvaddr (out_badvaddr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [37:0] tg);
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        in_wdata = wd;
        in_tag   = tg;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.addr_ok = 1'b1;
        bus_if.data_ok = 1'b0;
        bus_if.rdata   = 32'h0;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_exc", 64'(out_exc), 64'h0);
        chk("rst_out_badvaddr", 64'(out_badvaddr), 64'h0);
        chk("rst_bus_req", 64'(bus_if.req), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        #1 rst_n = 1'b1;
        tick();

        // LB at 0x1003, sign-extended byte from lane 3
        drive(4'd0, 32'h0000_1003, 32'h0, 38'h0A);
        #1;
        chk("lb_bus_req", 64'(bus_if.req), 64'h1);
        chk("lb_wstrb", 64'(bus_if.wstrb), 64'h0);
        chk("lb_bus_addr", 64'(bus_if.addr), 64'h1003);
        chk("lb_in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = 32'h80aa_bbcc;
        #1;
        chk("lb_n1_out_valid", 64'(out_valid), 64'h0);
        tick();
        bus_if.data_ok = 1'b0;
        #1;
        chk("lb_n2_out_valid", 64'(out_valid), 64'h1);
        chk("lb_out_data", 64'(out_data), 64'hffff_ff80);
        chk("lb_out_tag", 64'(out_tag), 64'h0A);
        tick();
        chk("lb_popped", 64'(out_valid), 64'h0);

        // SW at 0x2002: address error on store
        drive(4'd7, 32'h0000_2002, 32'h1234_5678, 38'h0B);
        #1;
        chk("sw_bus_req", 64'(bus_if.req), 64'h0);
        chk("sw_in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("sw_out_valid", 64'(out_valid), 64'h1);
        chk("sw_out_exc", 64'(out_exc), 64'h1);
        chk("sw_exc_code", 64'(out_exc_code), 64'h05);
        chk("sw_badvaddr", 64'(out_badvaddr), 64'h2002);
        chk("sw_out_data", 64'(out_data), 64'h0);
        tick();
        chk("sw_popped", 64'(out_valid), 64'h0);

        // Fill both slots, third access blocked, in-order retire
        drive(4'd4, 32'h0000_0100, 32'h0, 38'hC1);
        tick();
        drive(4'd4, 32'h0000_0104, 32'h0, 38'hC2);
        tick();
        drive(4'd4, 32'h0000_0108, 32'h0, 38'hC3);
        #1;
        chk("full_in_ready", 64'(in_ready), 64'h0);
        chk("full_bus_req", 64'(bus_if.req), 64'h0);
        in_valid = 1'b0;
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = 32'h11;
        tick();
        bus_if.rdata = 32'h22;
        #1;
        chk("full_r1_data", 64'(out_data), 64'h11);
        chk("full_r1_tag", 64'(out_tag), 64'hC1);
        tick();
        bus_if.data_ok = 1'b0;
        #1;
        chk("full_r2_valid", 64'(out_valid), 64'h1);
        chk("full_r2_data", 64'(out_data), 64'h22);
        chk("full_r2_tag", 64'(out_tag), 64'hC2);
        chk("full_ready_again", 64'(in_ready), 64'h1);
        tick();
        chk("full_drained", 64'(out_valid), 64'h0);

        // WB back-pressure: head held stable, second capture kept
        out_ready = 1'b0;
        drive(4'd2, 32'h0000_0202, 32'h0, 38'hD1);
        tick();
        drive(4'd3, 32'h0000_0306, 32'h0, 38'hD2);
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = 32'h8001_1234;
        tick();
        in_valid = 1'b0;
        bus_if.rdata = 32'hfedc_0000;
        tick();
        bus_if.data_ok = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 64'(out_valid), 64'h1);
            chk("stall_data", 64'(out_data), 64'hffff_8001);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("stall_tag1", 64'(out_tag), 64'hD1);
        tick();
        chk("stall_r2_valid", 64'(out_valid), 64'h1);
        chk("stall_r2_data", 64'(out_data), 64'h0000_fedc);
        chk("stall_r2_tag", 64'(out_tag), 64'hD2);
        tick();
        chk("stall_drained", 64'(out_valid), 64'h0);

        // Flush with two loads outstanding
        drive(4'd4, 32'h0000_0400, 32'h0, 38'hE1);
        tick();
        drive(4'd4, 32'h0000_0404, 32'h0, 38'hE2);
        tick();
        drive(4'd4, 32'h0000_0408, 32'h0, 38'hE3);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'h0);
        chk("flush_bus_req", 64'(bus_if.req), 64'h0);
        tick();
        flush = 1'b0;
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = 32'hdead_0001;
        #1;
        chk("flush_still_full", 64'(in_ready), 64'h0);
        tick();
        bus_if.rdata = 32'hdead_0002;
        #1;
        chk("flush_absorb1", 64'(out_valid), 64'h0);
        tick();
        bus_if.data_ok = 1'b0;
        #1;
        chk("flush_absorb2", 64'(out_valid), 64'h0);
        chk("flush_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = 32'h33;
        #1;
        chk("flush_new_wait", 64'(out_valid), 64'h0);
        tick();
        bus_if.data_ok = 1'b0;
        #1;
        chk("flush_new_valid", 64'(out_valid), 64'h1);
        chk("flush_new_data", 64'(out_data), 64'h33);
        chk("flush_new_tag", 64'(out_tag), 64'hE3);
        tick();
        chk("flush_drained", 64'(out_valid), 64'h0);

        // SB lane placement
        drive(4'd5, 32'h0000_3002, 32'h0000_00a5, 38'h5B);
        #1;
        chk("sb_wr", 64'(bus_if.wr), 64'h1);
        chk("sb_wstrb", 64'(bus_if.wstrb), 64'h4);
        chk("sb_wdata", 64'(bus_if.wdata), 64'ha5a5_a5a5);
        chk("sb_size", 64'(bus_if.size), 64'h0);
        tick();
        in_valid = 1'b0;
        bus_if.data_ok = 1'b1;
        tick();
        bus_if.data_ok = 1'b0;
        #1;
        chk("sb_valid", 64'(out_valid), 64'h1);
        chk("sb_out_data", 64'(out_data), 64'h0);
        chk("sb_out_exc", 64'(out_exc), 64'h0);
        tick();

        // LWL at 0x0001
        drive(4'd8, 32'h0000_0001, 32'h1122_3344, 38'hF0);
`ifdef MEM_LR_EN
        #1;
        chk("lwl_bus_req", 64'(bus_if.req), 64'h1);
        chk("lwl_bus_addr", 64'(bus_if.addr), 64'h0);
        tick();
        in_valid = 1'b0;
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = 32'haabb_ccdd;
        tick();
        bus_if.data_ok = 1'b0;
        #1;
        chk("lwl_valid", 64'(out_valid), 64'h1);
        chk("lwl_data", 64'(out_data), 64'hccdd_3344);
`else
        #1;
        chk("lwl_ri_bus_req", 64'(bus_if.req), 64'h0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("lwl_ri_exc", 64'(out_exc), 64'h1);
        chk("lwl_ri_code", 64'(out_exc_code), 64'h0a);
        chk("lwl_ri_badvaddr", 64'(out_badvaddr), 64'h1);
`endif
        tick();
        chk("lwl_drained", 64'(out_valid), 64'h0);

        // Stray data_ok while idle is ignored
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = 32'hbad0_bad0;
        tick();
        bus_if.data_ok = 1'b0;
        #1;
        chk("stray_no_valid", 64'(out_valid), 64'h0);
        drive(4'd1, 32'h0000_5001, 32'h0, 38'h77);
        tick();
        in_valid = 1'b0;
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = 32'h0000_9900;
        tick();
        bus_if.data_ok = 1'b0;
        #1;
        chk("lbu_valid", 64'(out_valid), 64'h1);
        chk("lbu_data", 64'(out_data), 64'h99);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
